// File: rtl/s713_pkg.sv
// Shared types and constants for the s713 state bank and its scan controller.
package s713_pkg;

  localparam int S713_STATE_W = 15;

  typedef logic [S713_STATE_W-1:0] s713_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } s713_scan_st_e;

  localparam s713_state_t S713_RESET_VAL = 15'h0000;

endpackage

// File: rtl/s713_scan_ctrl.sv
// Scan sequencer: 4-phase req/ack handshake, shift counter and capture-drop detection.
//   state | meaning
//   IDLE  | functional mode, captures allowed, waiting for scan_req_i
//   SHIFT | chain shifting one bit per cycle, LEN cycles total
//   DONE  | shift finished, scan_ack_o held until scan_req_i drops
module s713_scan_ctrl
  import s713_pkg::*;
#(
  parameter int LEN   = 15,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_req_i,
  input  logic          cap_en_i,
  output s713_scan_st_e scan_st_o,
  output logic          scan_ack_o,
  output logic          scan_busy_o,
  output logic          cap_miss_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  s713_scan_st_e    st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             miss_q, miss_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    ack_d  = ack_q;
    busy_d = busy_q;
    miss_d = 1'b0;
    case (st_q)
      IDLE: begin
        if (scan_req_i) begin
          st_d   = SHIFT;
          cnt_d  = '0;
          busy_d = 1'b1;
          miss_d = cap_en_i;
        end
      end
      SHIFT: begin
        miss_d = cap_en_i;
        // Counter saturates at the last shift; the request level is ignored here.
        if (cnt_q == LAST_CNT) begin
          st_d   = DONE;
          busy_d = 1'b0;
          ack_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        miss_d = cap_en_i;
        if (!scan_req_i) begin
          st_d  = IDLE;
          ack_d = 1'b0;
        end
      end
      default: begin
        st_d   = IDLE;
        ack_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
      miss_q <= miss_d;
    end
  end

  assign scan_st_o   = st_q;
  assign scan_ack_o  = ack_q;
  assign scan_busy_o = busy_q;
  assign cap_miss_o  = miss_q;

endmodule

// File: rtl/s713_state_bank.sv
// s713 present-state flops with functional capture and a serial scan chain (bit 0 = scan out).
// Optional S713_STATE_PARITY_EN: even-parity flop at the chain MSB plus sticky parity_err_o.
module s713_state_bank
  import s713_pkg::*;
#(
  parameter int                 STATE_W   = S713_STATE_W,
  parameter logic [STATE_W-1:0] RESET_VAL = S713_RESET_VAL,
  parameter int                 CNT_W     = $clog2(STATE_W + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] ns_i,
  input  logic               cap_en_i,
  output logic [STATE_W-1:0] state_o,
  input  logic               scan_req_i,
  output logic               scan_ack_o,
  output logic               scan_busy_o,
  input  logic               scan_si_i,
  output logic               scan_so_o,
  output logic               cap_miss_o
`ifdef S713_STATE_PARITY_EN
  ,
  output logic               parity_err_o
`endif
);

`ifdef S713_STATE_PARITY_EN
  localparam int LEN = STATE_W + 1;
`else
  localparam int LEN = STATE_W;
`endif

  s713_scan_st_e      scan_st;
  logic [STATE_W-1:0] state_q, state_d;
  logic               chain_top_in;
  logic               in_idle;
  logic               do_cap;
  logic               do_shift;

  // Scan wins over capture in IDLE; outside IDLE captures are always dropped.
  assign in_idle  = (scan_st == IDLE);
  assign do_cap   = in_idle & ~scan_req_i & cap_en_i;
  assign do_shift = (scan_st == SHIFT);

  s713_scan_ctrl #(
    .LEN   (LEN),
    .CNT_W (CNT_W)
  ) u_scan_ctrl (
    .clk         (clk),
    .rst         (rst),
    .scan_req_i  (scan_req_i),
    .cap_en_i    (cap_en_i),
    .scan_st_o   (scan_st),
    .scan_ack_o  (scan_ack_o),
    .scan_busy_o (scan_busy_o),
    .cap_miss_o  (cap_miss_o)
  );

`ifdef S713_STATE_PARITY_EN
  logic par_q, par_d;
  logic err_q, err_d;

  // par sits above state in the chain: it feeds state MSB and takes scan_si_i.
  assign chain_top_in = par_q;

  always_comb begin
    par_d = par_q;
    if (do_cap) begin
      par_d = ^ns_i;
    end else if (do_shift) begin
      par_d = scan_si_i;
    end
    err_d = err_q | (in_idle & ((^state_q) ^ par_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= ^RESET_VAL;
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  end

  assign parity_err_o = err_q;
`else
  assign chain_top_in = scan_si_i;
`endif

  always_comb begin
    state_d = state_q;
    if (do_cap) begin
      state_d = ns_i;
    end else if (do_shift) begin
      state_d = {chain_top_in, state_q[STATE_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o   = state_q;
  assign scan_so_o = state_q[0];

endmodule

// File: tb/tb_s713_state_bank.sv
// Bench for s713_state_bank: chain-level reference model checked every cycle plus directed literals.
// Follows S713_STATE_PARITY_EN so the parity build is exercised with the same stimulus.
module tb_s713_state_bank;
  import s713_pkg::*;

  localparam int W = 15;
`ifdef S713_STATE_PARITY_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ns_i;
  logic         cap_en_i;
  logic [W-1:0] state_o;
  logic         scan_req_i;
  logic         scan_ack_o;
  logic         scan_busy_o;
  logic         scan_si_i;
  logic         scan_so_o;
  logic         cap_miss_o;
`ifdef S713_STATE_PARITY_EN
  logic         parity_err_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  s713_state_bank dut (
    .clk         (clk),
    .rst         (rst),
    .ns_i        (ns_i),
    .cap_en_i    (cap_en_i),
    .state_o     (state_o),
    .scan_req_i  (scan_req_i),
    .scan_ack_o  (scan_ack_o),
    .scan_busy_o (scan_busy_o),
    .scan_si_i   (scan_si_i),
    .scan_so_o   (scan_so_o),
    .cap_miss_o  (cap_miss_o)
`ifdef S713_STATE_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Whole chain image as the bench sees it: parity bit (if present) above the state word.
  function automatic logic [LEN-1:0] full(input logic [W-1:0] v);
`ifdef S713_STATE_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  // Reference model: phase 0 = functional, 1 = shifting, 2 = waiting for request release.
  logic [LEN-1:0] m_chain;
  int             m_phase;
  int             m_shifts;
  logic           m_ack, m_busy, m_miss, m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_chain  = full(S713_RESET_VAL);
      m_phase  = 0;
      m_shifts = 0;
      m_ack    = 1'b0;
      m_busy   = 1'b0;
      m_miss   = 1'b0;
      m_err    = 1'b0;
    end else begin
      m_miss = 1'b0;
      if (m_phase == 0 && (^m_chain) != 1'b0) m_err = 1'b1;
      case (m_phase)
        0: begin
          if (scan_req_i) begin
            m_phase  = 1;
            m_shifts = 0;
            m_busy   = 1'b1;
            m_miss   = cap_en_i;
          end else if (cap_en_i) begin
            m_chain = full(ns_i);
          end
        end
        1: begin
          m_chain  = {scan_si_i, m_chain[LEN-1:1]};
          m_shifts = m_shifts + 1;
          m_miss   = cap_en_i;
          if (m_shifts == LEN) begin
            m_phase = 2;
            m_busy  = 1'b0;
            m_ack   = 1'b1;
          end
        end
        default: begin
          m_miss = cap_en_i;
          if (!scan_req_i) begin
            m_phase = 0;
            m_ack   = 1'b0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_state",  32'(state_o),     32'(m_chain[W-1:0]));
      check("mdl_so",     32'(scan_so_o),   32'(m_chain[0]));
      check("mdl_ack",    32'(scan_ack_o),  32'(m_ack));
      check("mdl_busy",   32'(scan_busy_o), 32'(m_busy));
      check("mdl_miss",   32'(cap_miss_o),  32'(m_miss));
`ifdef S713_STATE_PARITY_EN
      check("mdl_perr",   32'(parity_err_o), 32'(m_err));
`endif
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drives LEN shift cycles starting at SHIFT cycle 0; optional capture, request drop or reset.
  task automatic run_shift(input logic [LEN-1:0] pat, input int cap_at, input int drop_at,
                           input int rst_at);
    for (int k = 0; k < LEN; k++) begin
      scan_si_i = pat[k];
      cap_en_i  = (k == cap_at);
      if (k == drop_at) scan_req_i = 1'b0;
      if (k == rst_at) begin
        rst        = 1'b1;
        scan_req_i = 1'b0;
        cap_en_i   = 1'b0;
        cyc();
        rst = 1'b0;
        return;
      end
      cyc();
      if (k == cap_at) check("cap_miss_in_shift", 32'(cap_miss_o), 32'h1);
    end
    cap_en_i = 1'b0;
    check("ack_after_shift",  32'(scan_ack_o),  32'h1);
    check("busy_after_shift", 32'(scan_busy_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LEN-1:0] so_ref;
    logic [LEN-1:0] si_pat;
    rst        = 1'b1;
    ns_i       = '0;
    cap_en_i   = 1'b0;
    scan_req_i = 1'b0;
    scan_si_i  = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset_state", 32'(state_o),     32'h0);
    check("reset_ack",   32'(scan_ack_o),  32'h0);
    check("reset_busy",  32'(scan_busy_o), 32'h0);
    check("reset_miss",  32'(cap_miss_o),  32'h0);
    check("reset_so",    32'(scan_so_o),   32'h0);
    rst = 1'b0;

    // Capture 5A3C
    ns_i     = 15'h5A3C;
    cap_en_i = 1'b1;
    check("cap_before_edge", 32'(state_o), 32'h0);
    cyc();
    cap_en_i = 1'b0;
    check("cap_after_edge", 32'(state_o),    32'h5A3C);
    check("cap_no_miss",    32'(cap_miss_o), 32'h0);
    cyc();

    // Unload 5A3C LSB first while loading 7FFF (parity bit 1 when present)
    scan_req_i = 1'b1;
    cyc();
    check("busy_on_entry", 32'(scan_busy_o), 32'h1);
    so_ref = full(15'h5A3C);
    si_pat = full(15'h7FFF);
    for (int k = 0; k < LEN; k++) begin
      check("so_seq",    32'(scan_so_o),   32'(so_ref[k]));
      check("busy_seq",  32'(scan_busy_o), 32'h1);
      scan_si_i = si_pat[k];
      cyc();
    end
    check("scan_ack_done",  32'(scan_ack_o),  32'h1);
    check("scan_busy_done", 32'(scan_busy_o), 32'h0);
    check("scan_loaded",    32'(state_o),     32'h7FFF);
    cyc();
    check("ack_held", 32'(scan_ack_o), 32'h1);
    scan_req_i = 1'b0;
    cyc();
    check("ack_released", 32'(scan_ack_o), 32'h0);

    // Collision: request and capture together
    ns_i       = 15'h1234;
    cap_en_i   = 1'b1;
    scan_req_i = 1'b1;
    cyc();
    check("coll_miss",  32'(cap_miss_o),  32'h1);
    check("coll_state", 32'(state_o),     32'h7FFF);
    check("coll_busy",  32'(scan_busy_o), 32'h1);
    run_shift(full(15'h2AAA), -1, -1, -1);
    check("coll_result", 32'(state_o), 32'h2AAA);
    scan_req_i = 1'b0;
    cyc();

    // Capture during shift cycle 5, request dropped at cycle 2 (ignored)
    scan_req_i = 1'b1;
    ns_i       = 15'h0055;
    cyc();
    run_shift(full(15'h1357), 5, 2, -1);
    check("capshift_result", 32'(state_o), 32'h1357);
    cyc();
    check("capshift_ack_fall", 32'(scan_ack_o), 32'h0);

    // Reset at shift cycle 7
    scan_req_i = 1'b1;
    cyc();
    run_shift(full(15'h7E01), -1, -1, 7);
    check("rst_mid_state", 32'(state_o),     32'h0);
    check("rst_mid_busy",  32'(scan_busy_o), 32'h0);
    check("rst_mid_ack",   32'(scan_ack_o),  32'h0);
    check("rst_mid_so",    32'(scan_so_o),   32'h0);
    ns_i     = 15'h0F0F;
    cap_en_i = 1'b1;
    cyc();
    cap_en_i = 1'b0;
    check("rst_then_cap", 32'(state_o), 32'h0F0F);
    cyc();

`ifdef S713_STATE_PARITY_EN
    // Load state 0001 with a wrong parity bit of 0
    scan_req_i = 1'b1;
    cyc();
    run_shift(16'h0001, -1, -1, -1);
    scan_req_i = 1'b0;
    cyc();
    cyc();
    check("perr_set", 32'(parity_err_o), 32'h1);
    ns_i     = 15'h0003;
    cap_en_i = 1'b1;
    cyc();
    cap_en_i = 1'b0;
    cyc();
    check("perr_sticky",      32'(parity_err_o), 32'h1);
    check("perr_good_cap",    32'(state_o),      32'h0003);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("perr_cleared", 32'(parity_err_o), 32'h0);
`endif

    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
